peripheral_mpi_ahb3_initiator: RTL
==================================

Name: peripheral_mpi_ahb3_initiator

Overview:
AHB3-Lite initiator (bus master) that turns single generic-bus requests into AHB3-Lite single transfers. It is the counterpart to the team's AHB3 MPI slave wrapper. It lets a core-side engine (e.g. MPI message DMA) reach a remote peripheral_mpi_ahb3 slave or memory. Exactly one outstanding transfer at a time; no bursts, no pipelining of consecutive requests.

Parameters:
PLEN, 32, AHB address width
XLEN, 32, AHB data width; HSIZE is derived as log2(XLEN/8)
TIMEOUT, 256, wait-state limit per transfer; used only with the optional feature

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
bus_addr  in  PLEN  request address
bus_we  in  1  1=write, 0=read
bus_en  in  1  request valid; held high until bus_ack or bus_err
bus_data_in  in  XLEN  write data
bus_data_out  out  XLEN  read data; valid while bus_ack=1
bus_ack  out  1  one-cycle completion pulse (OKAY)
bus_err  out  1  one-cycle completion pulse (ERROR or timeout)
ahb3_hsel_o  out  1  slave select
ahb3_haddr_o  out  PLEN  address
ahb3_hwdata_o  out  XLEN  write data
ahb3_hwrite_o  out  1  write flag
ahb3_hsize_o  out  3  transfer size
ahb3_hburst_o  out  3  burst type
ahb3_hprot_o  out  4  protection
ahb3_htrans_o  out  2  transfer type
ahb3_hmastlock_o  out  1  locked transfer
ahb3_hrdata_i  in  XLEN  read data
ahb3_hready_i  in  1  transfer done / wait state
ahb3_hresp_i  in  1  0=OKAY, 1=ERROR

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-low.
- Reset values: all outputs 0.
  - htrans_o=IDLE (2'b00), hsel_o=0, hmastlock_o=0.
  - bus_ack=0, bus_err=0, bus_data_out=0.
  - FSM in IDLE.
- Constant outputs: hburst_o=SINGLE (3'b000), hprot_o=4'b0011, hsize_o=log2(XLEN/8) (3'b010 at XLEN=32).
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - Captures addr, we and wdata into registers when bus_en=1; next state ADDR.
  - bus_en is ignored during the cycle bus_ack|bus_err is high.
- ADDR (address phase):
  - Drives htrans_o=NONSEQ, hsel_o=1, hmastlock_o=1, haddr_o and hwrite_o from the captured registers.
  - hmastlock_o is required because the MPI slave enables on hmastlock&hsel.
  - hready_i=1: next state DATA. hready_i=0: hold all address-phase signals.
- DATA (data phase):
  - htrans_o=IDLE, hsel_o=0, hmastlock_o=0.
  - hwdata_o = captured wdata, held for the whole phase.
  - hready_i=0: stay in DATA; this includes the first cycle of a 2-cycle ERROR response.
  - hready_i=1 and hresp_i=0: register hrdata_i into bus_data_out (reads only; unchanged on writes) and set bus_ack=1.
  - hready_i=1 and hresp_i=1: set bus_err=1 and leave bus_data_out unchanged.
  - In both completion cases, next state RESP.
- RESP: bus_ack/bus_err high for exactly this one cycle; next state IDLE.
- Latency with zero wait states: bus_en sampled at edge 0 → ADDR at cycle 1 → DATA at cycle 2 → ack/err at cycle 3. Each wait state adds one cycle.
- Back-to-back requests: the requester must drop bus_en the cycle after ack. Minimum spacing is 4 cycles per transfer.
- Reset mid-transfer: the FSM returns to IDLE on the next edge and outputs take reset values. No ack/err is produced for the aborted request.
- bus_en dropped mid-transfer is a protocol violation. The transfer still completes and the ack is still issued.

Optional Feature:
- Macro: MPI_AHB3_INITIATOR_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to ADDR and increments each cycle the FSM is in ADDR or DATA with hready_i=0.
  - On reaching TIMEOUT: next state RESP with bus_err=1, htrans_o forced IDLE, and the counter reset.
- When undefined: no counter exists and the FSM waits indefinitely for hready_i.

Decomposition:
- Package peripheral_mpi_ahb3_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HBURST_SINGLE
  - HSIZE_BYTE/HALF/WORD
  - HPROT_DATA_PRIV (4'b0011)
  - HRESP_OKAY/ERROR
  - state enum type (IDLE, ADDR, DATA, RESP)
- No sub-module: the FSM, capture registers and optional watchdog are small enough to live in one module.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0010, zero wait:
  - ADDR cycle shows htrans=NONSEQ, hwrite=1, hmastlock=1, hsel=1.
  - Next cycle hwdata=0xDEADBEEF.
  - bus_ack=1 at cycle 3 for exactly one cycle.
- Read 0x0000_0020 with 3 wait states and hrdata=0x12345678: ack at cycle 6, bus_data_out=0x12345678, bus_err stays 0.
- Read with 2-cycle ERROR response (hresp=1/hready=0, then hresp=1/hready=1): bus_err pulses once, bus_ack=0, bus_data_out unchanged.
- hready_i=0 during ADDR for 2 cycles: haddr, htrans=NONSEQ and hwrite stay stable; completion is delayed by 2 cycles.
- rst=0 asserted during DATA: the next edge gives htrans=IDLE, hsel=0 and no ack. A new write afterwards completes normally.
- With MPI_AHB3_INITIATOR_TIMEOUT_EN and TIMEOUT=8, hready held 0: bus_err pulses after 8 stall cycles and the FSM returns to IDLE. Without the macro, no err occurs within 1000 cycles.

Source files
------------

// File: rtl/peripheral_mpi_ahb3_pkg.sv
// +----------------------------------------------------------------------------+
// | peripheral_mpi_ahb3_pkg : shared AHB3-Lite encodings and initiator state   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package peripheral_mpi_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } ahb3_init_state_e;

  // HSIZE encodes the transfer width as log2 of the byte count.
  function automatic logic [2:0] hsize_for(input int xlen);
    return 3'($clog2(xlen / 8));
  endfunction

endpackage

`default_nettype wire

// File: rtl/peripheral_mpi_ahb3_initiator.sv
// +----------------------------------------------------------------------------+
// | peripheral_mpi_ahb3_initiator : generic-bus to AHB3-Lite single-transfer   |
// | master. Optional wait-state watchdog: MPI_AHB3_INITIATOR_TIMEOUT_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module peripheral_mpi_ahb3_initiator
  import peripheral_mpi_ahb3_pkg::*;
#(
  parameter int PLEN    = 32,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,

  input  logic [PLEN-1:0] bus_addr,
  input  logic            bus_we,
  input  logic            bus_en,
  input  logic [XLEN-1:0] bus_data_in,
  output logic [XLEN-1:0] bus_data_out,
  output logic            bus_ack,
  output logic            bus_err,

  output logic            ahb3_hsel_o,
  output logic [PLEN-1:0] ahb3_haddr_o,
  output logic [XLEN-1:0] ahb3_hwdata_o,
  output logic            ahb3_hwrite_o,
  output logic [2:0]      ahb3_hsize_o,
  output logic [2:0]      ahb3_hburst_o,
  output logic [3:0]      ahb3_hprot_o,
  output logic [1:0]      ahb3_htrans_o,
  output logic            ahb3_hmastlock_o,
  input  logic [XLEN-1:0] ahb3_hrdata_i,
  input  logic            ahb3_hready_i,
  input  logic            ahb3_hresp_i
);

  localparam logic [2:0] C_HSIZE = hsize_for(XLEN);

  ahb3_init_state_e state_q;
  logic [PLEN-1:0]  addr_q;
  logic             we_q;
  logic [XLEN-1:0]  wdata_q;
  logic [XLEN-1:0]  rdata_q;
  logic [1:0]       htrans_q;
  logic             hsel_q;
  logic             lock_q;
  logic             ack_q;
  logic             err_q;
  logic             w_expire;

`ifdef MPI_AHB3_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  assign w_expire = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Counts every stalled cycle of one transfer, address and data phase together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      cnt_q <= '0;
    end else if ((state_q == ST_ADDR || state_q == ST_DATA) && !ahb3_hready_i) begin
      cnt_q <= w_expire ? '0 : cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign w_expire       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hsel_q   <= 1'b0;
      lock_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus_en) begin
            addr_q   <= bus_addr;
            we_q     <= bus_we;
            wdata_q  <= bus_data_in;
            htrans_q <= HTRANS_NONSEQ;
            hsel_q   <= 1'b1;
            lock_q   <= 1'b1;
            state_q  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (ahb3_hready_i) begin
            htrans_q <= HTRANS_IDLE;
            hsel_q   <= 1'b0;
            lock_q   <= 1'b0;
            state_q  <= ST_DATA;
          end else if (w_expire) begin
            htrans_q <= HTRANS_IDLE;
            hsel_q   <= 1'b0;
            lock_q   <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_DATA: begin
          if (ahb3_hready_i) begin
            if (ahb3_hresp_i == HRESP_OKAY) begin
              ack_q <= 1'b1;
              if (!we_q) begin
                rdata_q <= ahb3_hrdata_i;
              end
            end else begin
              err_q <= 1'b1;
            end
            state_q <= ST_RESP;
          end else if (w_expire) begin
            err_q   <= 1'b1;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_data_out     = rdata_q;
  assign bus_ack          = ack_q;
  assign bus_err          = err_q;

  assign ahb3_hsel_o      = hsel_q;
  assign ahb3_haddr_o     = addr_q;
  assign ahb3_hwdata_o    = wdata_q;
  assign ahb3_hwrite_o    = we_q;
  assign ahb3_htrans_o    = htrans_q;
  assign ahb3_hmastlock_o = lock_q;
  assign ahb3_hsize_o     = C_HSIZE;
  assign ahb3_hburst_o    = HBURST_SINGLE;
  assign ahb3_hprot_o     = HPROT_DATA_PRIV;

endmodule

`default_nettype wire
